// File: rtl/window_scan_ctrl_if.sv
// Stream and result handshake bundle for window_scan_ctrl.
// master = upstream/downstream host side, slave = the controller.
interface window_scan_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             pad_zero;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       corner_type;
    logic [CNT_W-1:0] out_row;
    logic [CNT_W-1:0] out_col;
    logic             busy;
    logic             frame_done;

    modport master (
        output start, in_valid, out_ready,
        input  in_ready, shift_en, pad_zero, out_valid, corner_type,
               out_row, out_col, busy, frame_done
    );

    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, shift_en, pad_zero, out_valid, corner_type,
               out_row, out_col, busy, frame_done
    );
endinterface

// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 window datapath: fill, run, zero-padded flush.
// Optional WSC_STALL_CNT_EN adds a saturating output-stall cycle counter port.
module window_scan_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef WSC_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    window_scan_ctrl_if.slave bus
);

    // state | meaning
    // IDLE  | waiting for start
    // FILL  | priming line buffers, first IMG_W+1 pixels, no results
    // RUN   | one result per accepted pixel
    // FLUSH | IMG_W+1 advances with zero fed into the line buffers
    // DONE  | waiting for the last result to be taken
    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] W_CNT  = CNT_W'(IMG_W);

    state_t           state;
    logic [CNT_W-1:0] in_row, in_col;
    logic [CNT_W-1:0] res_row, res_col;
    logic [CNT_W-1:0] flush_cnt;
    logic             out_valid_q, pad_zero_q, busy_q, frame_done_q;
    logic [3:0]       corner_q;
    logic [CNT_W-1:0] out_row_q, out_col_q;
    logic             in_ready_c, adv, produce, out_hs;

    function automatic logic [3:0] corner_of(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] c);
        logic top, bot, left, right;
        top   = (r == '0);
        bot   = (r == H_LAST);
        left  = (c == '0);
        right = (c == W_LAST);
        if (top && left)        return 4'd1;
        else if (top && right)  return 4'd2;
        else if (bot && left)   return 4'd5;
        else if (bot && right)  return 4'd6;
        else if (left)          return 4'd3;
        else if (right)         return 4'd4;
        else if (top || bot)    return 4'd7;
        else                    return 4'd8;
    endfunction

    always_comb begin
        in_ready_c = 1'b0;
        adv        = 1'b0;
        case (state)
            FILL: begin
                in_ready_c = 1'b1;
                adv        = bus.in_valid;
            end
            RUN: begin
                in_ready_c = !out_valid_q || bus.out_ready;
                adv        = bus.in_valid && in_ready_c;
            end
            FLUSH:   adv = !out_valid_q || bus.out_ready;
            default: ;
        endcase
    end

    assign produce = adv && (state == RUN || state == FLUSH);
    assign out_hs  = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_row       <= '0;
            in_col       <= '0;
            res_row      <= '0;
            res_col      <= '0;
            flush_cnt    <= '0;
            out_valid_q  <= 1'b0;
            pad_zero_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            corner_q     <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            frame_done_q <= 1'b0;

            // A producing advance wins over a plain handshake: no bubble on reload.
            if (produce) begin
                out_valid_q <= 1'b1;
                out_row_q   <= res_row;
                out_col_q   <= res_col;
                corner_q    <= corner_of(res_row, res_col);
                if (res_col == W_LAST) begin
                    res_col <= '0;
                    if (res_row != H_LAST) res_row <= res_row + 1'b1;
                end else begin
                    res_col <= res_col + 1'b1;
                end
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
                corner_q    <= '0;
            end

            if (adv && state != FLUSH) begin
                if (in_col == W_LAST) begin
                    in_col <= '0;
                    if (in_row != H_LAST) in_row <= in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end

            case (state)
                IDLE: if (bus.start) begin
                    state   <= FILL;
                    busy_q  <= 1'b1;
                    in_row  <= '0;
                    in_col  <= '0;
                    res_row <= '0;
                    res_col <= '0;
                end
                // Pixel index IMG_W sits at (1,0): accepting it completes the fill.
                FILL: if (adv && in_row == CNT_W'(1) && in_col == '0) state <= RUN;
                RUN: if (adv && in_row == H_LAST && in_col == W_LAST) begin
                    state      <= FLUSH;
                    pad_zero_q <= 1'b1;
                    flush_cnt  <= W_CNT;
                end
                FLUSH: if (adv) begin
                    if (flush_cnt == '0) begin
                        state      <= DONE;
                        pad_zero_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                DONE: if (out_hs) begin
                    state        <= IDLE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WSC_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                         stall_cnt <= '0;
        else if (state == IDLE && bus.start)             stall_cnt <= '0;
        else if (out_valid_q && !bus.out_ready && stall_cnt != 16'hFFFF)
                                                         stall_cnt <= stall_cnt + 1'b1;
    end
`endif

    assign bus.in_ready    = in_ready_c;
    assign bus.shift_en    = adv;
    assign bus.pad_zero    = pad_zero_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.corner_type = corner_q;
    assign bus.out_row     = out_row_q;
    assign bus.out_col     = out_col_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: doc/window_scan_ctrl.md
Name: window_scan_ctrl

Overview:
Raster-scan sequencer for the 3x3 filter datapath (computing_block plus its line buffers and window registers).
- Accepts a pixel stream with valid/ready.
- Drives the line-buffer/window shift enable.
- Tracks the coordinate of the current window centre and generates the 4-bit corner_type code for that centre.
- Emits one result-valid per pixel with backpressure.
- After the last input pixel, flushes the remaining IMG_W+1 window positions, with the line buffers fed zero.

Parameters:
- IMG_W, 8, image width in pixels; legal range 3 to 2^CNT_W-1.
- IMG_H, 8, image height in lines; legal range 2 to 2^CNT_W-1.
- CNT_W, 8, width of row and column counters.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, synchronous reset, active-high.
- start, input, 1, one-cycle pulse that arms a frame; ignored while busy=1.
- in_valid, input, 1, pixel available on the upstream stream.
- in_ready, output, 1, controller accepts a pixel this cycle.
- shift_en, output, 1, advance line buffers/window by one position (combinational, same cycle as the advance).
- pad_zero, output, 1, high during FLUSH; the line-buffer input mux selects 0.
- out_valid, output, 1, corner_type/out_row/out_col valid for the current datapath result.
- out_ready, input, 1, downstream accepts the result.
- corner_type, output, 4, border classification of the centre pixel.
- out_row, output, CNT_W, centre row.
- out_col, output, CNT_W, centre column.
- busy, output, 1, frame in progress.
- frame_done, output, 1, one-cycle pulse after the final result handshake.

Behaviour:
- Reset values: in_ready=0, shift_en=0, pad_zero=0, out_valid=0, corner_type=0, out_row=0, out_col=0, busy=0, frame_done=0. FSM goes to IDLE; all counters clear.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is issued, and the next start begins a fresh frame.
- FSM states: IDLE, FILL, RUN, FLUSH, DONE.
  - IDLE: in_ready=0. start goes to FILL and sets busy=1.
  - FILL: in_ready=1. Each in_valid&in_ready is an advance. After IMG_W+1 advances, go to RUN. No outputs are produced in FILL.
  - RUN: in_ready = !out_valid | out_ready. Each accepted pixel is an advance and loads a new result.
    - When input pixel IMG_W*IMG_H-1 is accepted, go to FLUSH.
  - FLUSH: in_ready=0, pad_zero=1. An advance occurs whenever !out_valid | out_ready. After IMG_W+1 flush advances, go to DONE.
  - DONE: wait until the final result handshakes (out_valid & out_ready). Then pulse frame_done, drop busy, and go to IDLE.
- Advance count k is 1-based per frame.
  - Advance k > IMG_W+1 registers the result for centre index k-IMG_W-2, in raster order: row = idx / IMG_W, col = idx % IMG_W.
  - Total advances per frame = IMG_W*IMG_H + IMG_W + 1.
  - Results per frame = IMG_W*IMG_H.
- Output register is one entry deep. out_valid rises the cycle after a producing advance.
  - out_valid holds, with outputs stable, until out_ready.
  - A simultaneous handshake and new producing advance reloads the register with no bubble.
  - Throughput is one result per cycle with in_valid=out_ready=1.
- corner_type encoding for centre (r,c), with W=IMG_W and H=IMG_H:
  - 1: r=0, c=0.
  - 2: r=0, c=W-1.
  - 3: c=0, 0<r<H-1.
  - 4: c=W-1, 0<r<H-1.
  - 5: r=H-1, c=0.
  - 6: r=H-1, c=W-1.
  - 7: r=0 or r=H-1, 0<c<W-1.
  - 8: all other positions (full window).
  - 0: only when out_valid=0.
- Counters:
  - out_col wraps from W-1 to 0 and increments out_row.
  - out_row never exceeds H-1.
  - The input column/row counters wrap the same way.
- start while busy=1 is ignored. An in_valid pulse in IDLE or DONE is not accepted.

Optional Feature:
- Macro: WSC_STALL_CNT_EN.
- Defined: adds output port stall_cnt [15:0], reset to 0 and cleared on an accepted start.
  - Increments each cycle out_valid=1 & out_ready=0, saturating at 16'hFFFF.
  - Holds its value after frame_done until the next start.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=3, in_valid=out_ready=1 continuous, start pulse:
  - 5 FILL advances, then first out_valid the cycle after advance 6 with (0,0), corner_type=1.
  - 12 results total; 5 FLUSH advances with pad_zero=1; frame_done exactly once; 17 shift_en pulses total.
- Same image, corner_type sequence check, rows 0 to 2 = 1,7,7,2 / 3,8,8,4 / 5,7,7,6.
- out_ready held 0 for 4 cycles at result (1,1):
  - out_valid, outputs and in_ready=0 held; no shift_en in those cycles.
  - With WSC_STALL_CNT_EN defined, stall_cnt=4 at end of frame.
- in_valid toggled 1/0 every cycle in RUN: shift_en only on accepted cycles; result order unchanged; FLUSH unaffected by in_valid.
- rst asserted at result (2,1) of an IMG_W=8, IMG_H=8 frame: next cycle all outputs at reset values; a new start yields a full 64-result frame starting at (0,0).
- start pulsed in RUN and again in DONE: both ignored; single frame_done; busy low only after it.
